piso_serial_tx: RTL

//  Parallel-in serial-out frame transmitter built on negative-edge D flip-flop storage.

---
 rtl/piso_serial_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// ---------------------------------------------------------------------------
// piso_serial_tx
//   Parallel-in serial-out frame transmitter. A WIDTH-bit word is latched on
//   accept and shifted out LSB-first on SO as: start bit (0), data bits,
//   optional even-parity bit, stop bit (1). All state lives in flip-flops
//   clocked on the FALLING edge of C, and every output is a register.
//
//   Build option: define TX_PARITY_EN to insert an even-parity bit between
//   the last data bit and the stop bit. The port list is the same either way.
//
// Ports
//   C     in   1      clock, all state changes on the falling edge
//   RE_N  in   1      asynchronous active-low reset
//   D     in   WIDTH  parallel word, sampled only on the accept edge
//   LD    in   1      load request, honoured only while RDY=1
//   RDY   out  1      idle and able to accept LD
//   SO    out  1      serial line, idles high
//   BUSY  out  1      high while a frame is on SO
//   DONE  out  1      one-cycle pulse after the stop bit
// ---------------------------------------------------------------------------
module piso_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RE_N,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  output logic             RDY,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             so_reg, so_next;
  logic             rdy_reg, rdy_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef TX_PARITY_EN
  // Parity is taken from the word at accept time, since the shift register
  // no longer holds it once the last data bit has gone out.
  logic             parity_reg, parity_next;
`endif

  always_ff @(negedge C or negedge RE_N) begin
    if (!RE_N) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      so_reg     <= 1'b1;
      rdy_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_next;
      so_reg     <= so_next;
      rdy_reg    <= rdy_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Outputs are registered from the next-state values, so the line value for
  // a state appears on the same edge that enters that state.
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    cnt_next    = cnt_reg;
    so_next     = 1'b1;
    done_next   = 1'b0;
`ifdef TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (LD) begin
          shreg_next  = D;
          cnt_next    = '0;
`ifdef TX_PARITY_EN
          parity_next = ^D;
`endif
          state_next  = START;
          so_next     = 1'b0;
        end
      end
      START: begin
        // Leaving the start bit puts data bit 0 on the line.
        state_next = DATA;
        so_next    = shreg_reg[0];
        shreg_next = shreg_reg >> 1;
      end
      DATA: begin
        // cnt_reg is the index of the data bit currently on the line.
        if (cnt_reg == LAST_BIT) begin
`ifdef TX_PARITY_EN
          state_next = PAR;
          so_next    = parity_reg;
`else
          state_next = STOP;
          so_next    = 1'b1;
`endif
        end else begin
          so_next    = shreg_reg[0];
          shreg_next = shreg_reg >> 1;
          cnt_next   = cnt_reg + CNT_W'(1);
        end
      end
`ifdef TX_PARITY_EN
      PAR: begin
        state_next = STOP;
        so_next    = 1'b1;
      end
`endif
      STOP: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    rdy_next  = (state_next == IDLE);
    busy_next = (state_next != IDLE);
  end

  assign SO   = so_reg;
  assign RDY  = rdy_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;

endmodule
